// File: rtl/uarc_sender.sv
// uarc_sender: drives one UARC operation (kill/incept/send/stream) onto a set
// of buses, tracks which buses still owe an acknowledge, and reports the
// outcome with a one-cycle done pulse. TOTAL_BUSES must be at least 1.
module uarc_sender #(
  parameter int WORD_WIDTH  = 32,
  parameter int TOTAL_BUSES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  // core request side
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [TOTAL_BUSES-1:0] req_mask,
  input  logic [WORD_WIDTH-1:0]  req_data,
  input  logic [WORD_WIDTH-1:0]  req_incept_permission,
  input  logic [WORD_WIDTH-1:0]  req_incept_address,
  input  logic [WORD_WIDTH-1:0]  self_permission,
  input  logic [WORD_WIDTH-1:0]  self_address,
  input  logic                   abort,
  output logic                   done,
  output logic                   done_aborted,
  output logic [TOTAL_BUSES-1:0] unacked,
  // bus side
  output logic                   global_kill,
  output logic                   global_incept,
  output logic                   global_send,
  output logic                   global_stream,
  output logic [WORD_WIDTH-1:0]  global_data,
  output logic [WORD_WIDTH-1:0]  global_self_permission,
  output logic [WORD_WIDTH-1:0]  global_self_address,
  output logic [WORD_WIDTH-1:0]  global_incept_permission,
  output logic [WORD_WIDTH-1:0]  global_incept_address,
  output logic [TOTAL_BUSES-1:0] sender_enables,
  input  logic [TOTAL_BUSES-1:0] sender_kill_acks,
  input  logic [TOTAL_BUSES-1:0] sender_incept_acks,
  input  logic [TOTAL_BUSES-1:0] sender_send_acks,
  input  logic [TOTAL_BUSES-1:0] sender_stream_acks
);

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_t;

  typedef enum logic [1:0] {
    OP_KILL   = 2'd0,
    OP_INCEPT = 2'd1,
    OP_SEND   = 2'd2,
    OP_STREAM = 2'd3
  } op_t;

  state_t                 r_state;
  op_t                    r_op;
  logic [TOTAL_BUSES-1:0] r_pending;
  logic                   r_done;
  logic                   r_done_aborted;
  logic [TOTAL_BUSES-1:0] r_unacked;
  logic [WORD_WIDTH-1:0]  r_data;
  logic [WORD_WIDTH-1:0]  r_self_permission;
  logic [WORD_WIDTH-1:0]  r_self_address;
  logic [WORD_WIDTH-1:0]  r_incept_permission;
  logic [WORD_WIDTH-1:0]  r_incept_address;

  state_t                 w_next_state;
  logic [TOTAL_BUSES-1:0] w_next_pending;
  logic                   w_next_done;
  logic                   w_next_done_aborted;
  logic [TOTAL_BUSES-1:0] w_next_unacked;
  logic                   w_accept;
  logic [TOTAL_BUSES-1:0] w_ack_vec;
  logic [TOTAL_BUSES-1:0] w_remaining;
  logic                   w_active;

  // Only the acknowledge family that matches the operation in flight counts.
  always_comb begin
    w_ack_vec = '0;
    case (r_op)
      OP_KILL:   w_ack_vec = sender_kill_acks;
      OP_INCEPT: w_ack_vec = sender_incept_acks;
      OP_SEND:   w_ack_vec = sender_send_acks;
      OP_STREAM: w_ack_vec = sender_stream_acks;
      default:   w_ack_vec = '0;
    endcase
  end

  assign w_remaining = r_pending & ~w_ack_vec;

  // Next-state logic: accept, completion (wins over abort), abort.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_next_state        = r_state;
    w_next_pending      = r_pending;
    w_next_done         = 1'b0;
    w_next_done_aborted = 1'b0;
    w_next_unacked      = '0;
    w_accept            = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (req_mask != '0) begin
            w_next_state   = S_ACTIVE;
            w_next_pending = req_mask;
          end else begin
            // nothing to drive: report completion straight away
            w_next_done = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        if (w_remaining == '0) begin
          w_next_state   = S_IDLE;
          w_next_pending = '0;
          w_next_done    = 1'b1;
        end else if (abort) begin
          w_next_state        = S_IDLE;
          w_next_pending      = '0;
          w_next_done         = 1'b1;
          w_next_done_aborted = 1'b1;
          w_next_unacked      = w_remaining;
        end else begin
          w_next_pending = w_remaining;
        end
      end
      default: begin
        w_next_state   = S_IDLE;
        w_next_pending = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Pending mask, completion report, and latched operation/payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op                <= OP_KILL;
      r_pending           <= '0;
      r_done              <= 1'b0;
      r_done_aborted      <= 1'b0;
      r_unacked           <= '0;
      r_data              <= '0;
      r_self_permission   <= '0;
      r_self_address      <= '0;
      r_incept_permission <= '0;
      r_incept_address    <= '0;
    end else begin
      r_pending      <= w_next_pending;
      r_done         <= w_next_done;
      r_done_aborted <= w_next_done_aborted;
      r_unacked      <= w_next_unacked;
      if (w_accept) begin
        r_op                <= op_t'(req_op);
        r_data              <= req_data;
        r_self_permission   <= self_permission;
        r_self_address      <= self_address;
        r_incept_permission <= req_incept_permission;
        r_incept_address    <= req_incept_address;
      end
    end
  end

  assign w_active       = (r_state == S_ACTIVE);
  assign req_ready      = (r_state == S_IDLE);
  assign global_kill    = w_active && (r_op == OP_KILL);
  assign global_incept  = w_active && (r_op == OP_INCEPT);
  assign global_send    = w_active && (r_op == OP_SEND);
  assign global_stream  = w_active && (r_op == OP_STREAM);
  assign sender_enables = w_active ? r_pending : '0;

  assign done         = r_done;
  assign done_aborted = r_done_aborted;
  assign unacked      = r_unacked;

  assign global_data              = r_data;
  assign global_self_permission   = r_self_permission;
  assign global_self_address      = r_self_address;
  assign global_incept_permission = r_incept_permission;
  assign global_incept_address    = r_incept_address;

endmodule

// File: doc/uarc_sender.md
UARC_SENDER -- requirements
Module: uarc_sender

Interface
REQ-001 Parameter WORD_WIDTH, default 32, data/permission/address width in bits.
REQ-002 Parameter TOTAL_BUSES, default 1, number of UARC buses driven; must be >= 1.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  core offers a bus operation.
REQ-006 req_ready  output  1  engine idle and able to accept a request.
REQ-007 req_op  input  2  operation: 0 kill, 1 incept, 2 send, 3 stream.
REQ-008 req_mask  input  TOTAL_BUSES  target buses (the core's bus_selections).
REQ-009 req_data, req_incept_permission, req_incept_address  input  WORD_WIDTH each  payload.
REQ-010 self_permission, self_address  input  WORD_WIDTH each  sender identity.
REQ-011 abort  input  1  cancel the operation in flight.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 done_aborted  output  1  valid with done; 1 if the operation ended by abort.
REQ-014 unacked  output  TOTAL_BUSES  buses still pending at completion; valid with done.
REQ-015 global_kill, global_incept, global_send, global_stream  output  1 each  operation strobes.
REQ-016 global_data, global_self_permission, global_self_address, global_incept_permission, global_incept_address  output  WORD_WIDTH each  bus payload.
REQ-017 sender_enables  output  TOTAL_BUSES  per-bus enable.
REQ-018 sender_kill_acks, sender_incept_acks, sender_send_acks, sender_stream_acks  input  TOTAL_BUSES each  per-bus acknowledges.

Function
REQ-019 The engine SHALL be a two-state FSM, IDLE and ACTIVE, plus a registered done/done_aborted/unacked stage.
REQ-020 req_ready SHALL equal (state == IDLE).
REQ-021 A request SHALL be accepted on a rising edge with req_valid & req_ready; op, mask and all payload/identity inputs are latched at that edge.
REQ-022 On accept with a nonzero mask, the engine SHALL enter ACTIVE and set pending = req_mask.
REQ-023 On accept with a zero mask, the engine SHALL stay IDLE, assert no strobe, and pulse done=1, done_aborted=0, unacked=0 in the next cycle.
REQ-024 In ACTIVE, exactly one global strobe, selected by the latched op, SHALL be 1; all strobes SHALL be 0 in IDLE.
REQ-025 sender_enables SHALL equal pending in ACTIVE and 0 in IDLE.
REQ-026 Only the ack vector matching the latched op SHALL count; each edge in ACTIVE, pending <= pending & ~ack_vector.
REQ-027 Acks on buses not pending, acks of another op type, and any ack in IDLE SHALL be ignored.
REQ-028 When (pending & ~ack_vector) == 0 at an edge, the engine SHALL return to IDLE and pulse done=1, done_aborted=0, unacked=0 in the following cycle.
REQ-029 Minimum latency SHALL be 2 cycles from accept edge to done: strobe visible the cycle after accept, ack sampled at that cycle's end, done the next cycle.
REQ-030 Payload outputs SHALL hold the latched values from accept until the next accept, including in IDLE.
REQ-031 With abort=1 at an edge in ACTIVE, the engine SHALL return to IDLE and pulse done=1, done_aborted=1, unacked = pending & ~ack_vector in the next cycle.
REQ-032 Completion SHALL take priority over abort when both occur at the same edge; done_aborted is then 0.
REQ-033 abort SHALL be ignored in IDLE.
REQ-034 A new request SHALL be acceptable in the cycle done is high, giving back-to-back operation.

Reset
REQ-035 reset SHALL force IDLE, pending=0, done=0, done_aborted=0, unacked=0, all strobes 0, sender_enables=0, and all payload outputs 0.
REQ-036 reset SHALL take priority over every other input; asserting it in ACTIVE drops all strobes and enables next cycle, with no done pulse.

Verification (TOTAL_BUSES=4, WORD_WIDTH=32)
REQ-037 send, mask=4'b0101, data=32'hDEADBEEF; send_acks=4'b0001 then 4'b0100 -> global_send=1, enables 0101->0100->0000; done 1 cycle after second ack; global_data=DEADBEEF throughout.
REQ-038 incept, mask=4'b1111; all incept_acks=1111 in first active cycle -> done exactly 2 cycles after accept, unacked=0.
REQ-039 kill, mask=4'b0011; only send_acks=0011 for 5 cycles, then abort -> enables stay 0011; done=1, done_aborted=1, unacked=0011.
REQ-040 stream, mask=0 -> no strobe, no enable; done next cycle; req_ready never drops.
REQ-041 stream, mask=4'b1000; stream_ack=1000 and abort=1 at the same edge -> done_aborted=0, unacked=0; second request accepted in the done cycle.
REQ-042 reset during ACTIVE send (mask=0110) -> all outputs 0 next cycle, req_ready=1, no done.
